// File: rtl/arm_playback_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_pkg: shared types, state encoding and defaults for arm playback  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arm_pkg;

  localparam int AXIS_W = 8;
  typedef logic [AXIS_W-1:0] axis_t;

  localparam axis_t HOME_POS_DEF = 8'd10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_MOVE    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_ADVANCE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

endpackage
`default_nettype wire

// File: rtl/arm_playback_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_playback_ctrl_if: operator controls, ROM port and joint outputs  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface arm_playback_ctrl_if
  import arm_pkg::*;
#(
  parameter int ADDR_W = 6
) ();

  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  axis_t             rom_data_x;
  axis_t             rom_data_y;
  axis_t             rom_data_z;
  axis_t             pos_x;
  axis_t             pos_y;
  axis_t             pos_z;
  logic              pos_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_index;

  modport master (
    output start, stop, loop_en, rom_data_x, rom_data_y, rom_data_z,
    input  rom_addr, pos_x, pos_y, pos_z, pos_valid, busy, done, cur_index
  );

  modport slave (
    input  start, stop, loop_en, rom_data_x, rom_data_y, rom_data_z,
    output rom_addr, pos_x, pos_y, pos_z, pos_valid, busy, done, cur_index
  );

endinterface
`default_nettype wire

// File: rtl/arm_playback_ctrl_axis_slew.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_slew: one rate-limited step of a joint position toward target   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_slew
  import arm_pkg::*;
#(
  parameter int STEP = 4
) (
  input  wire axis_t pos,
  input  wire axis_t target,
  output axis_t      next_pos,
  output logic       at_target
);

  localparam logic signed [AXIS_W:0] STEP_S = (AXIS_W+1)'(STEP);

  // One extra bit keeps the full 0..255 span signed without wrap.
  logic signed [AXIS_W:0] diff;

  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, pos});
    if (diff > STEP_S) begin
      next_pos = pos + AXIS_W'(STEP);
    end else if (diff < -STEP_S) begin
      next_pos = pos - AXIS_W'(STEP);
    end else begin
      next_pos = target;
    end
  end

  assign at_target = (next_pos == target);

endmodule
`default_nettype wire

// File: rtl/arm_playback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_playback_ctrl: walks waypoint ROM, slews x/y/z, dwells, advances |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arm_playback_ctrl
  import arm_pkg::*;
#(
  parameter int    ADDR_W     = 6,
  parameter int    NUM_POINTS = 64,
  parameter int    TICK_DIV   = 50000,
  parameter int    STEP       = 4,
  parameter int    HOLD_TICKS = 100,
  parameter axis_t HOME_POS   = HOME_POS_DEF
) (
  input wire clk,
  input wire rst,
  arm_playback_ctrl_if.slave bus
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam int                HOLD_W    = $clog2(HOLD_TICKS + 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_POINTS - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] index_q, index_d;
  axis_t [2:0]       pos_q, pos_d;
  axis_t [2:0]       target_q, target_d;
  logic              pos_valid_q, pos_valid_d;
  logic              start_low_q, start_low_d;
  axis_t [2:0]       rom_data;
  wire axis_t [2:0]  next_pos;
  wire [2:0]         at_target;
  logic              tick;
  logic              start_edge;
  logic              busy;

  assign rom_data = {bus.rom_data_z, bus.rom_data_y, bus.rom_data_x};

  for (genvar a = 0; a < 3; a++) begin : g_axis
    axis_slew #(.STEP(STEP)) u_slew (
      .pos       (pos_q[a]),
      .target    (target_q[a]),
      .next_pos  (next_pos[a]),
      .at_target (at_target[a])
    );
  end

  // Remembers "start was seen low"; resetting it to 0 means a start held
  // high through reset must drop and rise again before it counts.
  assign start_edge = bus.start & start_low_q;
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    index_d     = index_q;
    pos_d       = pos_q;
    target_d    = target_q;
    pos_valid_d = 1'b0;
    start_low_d = ~bus.start;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;

    if (bus.stop) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            index_d = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          target_d = rom_data;
          state_d  = ST_MOVE;
        end
        ST_MOVE: begin
          if (tick) begin
            pos_d       = next_pos;
            pos_valid_d = (next_pos != pos_q);
            if (&at_target) begin
              hold_d  = HOLD_INIT;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_ADVANCE;
          end else if (tick) begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_ADVANCE: begin
          if (index_q < LAST_IDX) begin
            index_d = index_q + 1'b1;
            state_d = ST_FETCH;
          end else if (bus.loop_en) begin
            index_d = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      hold_q      <= '0;
      index_q     <= '0;
      pos_q       <= {3{HOME_POS}};
      target_q    <= {3{HOME_POS}};
      pos_valid_q <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_q      <= hold_d;
      index_q     <= index_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      pos_valid_q <= pos_valid_d;
      start_low_q <= start_low_d;
    end
  end

  assign bus.rom_addr  = index_q;
  assign bus.cur_index = index_q;
  assign bus.pos_x     = pos_q[0];
  assign bus.pos_y     = pos_q[1];
  assign bus.pos_z     = pos_q[2];
  assign bus.pos_valid = pos_valid_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_arm_playback_ctrl.sv
`default_nettype none
// Bench for arm_playback_ctrl: directed scenarios plus random ROM playback,
// checked against a per-tick slew model of the joint positions.
module tb_arm_playback_ctrl;
  import arm_pkg::*;

  localparam int NP = 3;
  localparam int TD = 4;
  localparam int ST = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arm_playback_ctrl_if #(.ADDR_W(6)) a_if ();
  arm_playback_ctrl_if #(.ADDR_W(6)) b_if ();

  arm_playback_ctrl #(.ADDR_W(6), .NUM_POINTS(NP), .TICK_DIV(TD), .STEP(ST),
                      .HOLD_TICKS(2), .HOME_POS(8'd10))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  arm_playback_ctrl #(.ADDR_W(6), .NUM_POINTS(NP), .TICK_DIV(TD), .STEP(ST),
                      .HOLD_TICKS(0), .HOME_POS(8'd10))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  logic [7:0] rom_a [4][3];
  logic [7:0] rom_b [4][3];

  // Synchronous-read waypoint ROMs
  always @(posedge clk) begin
    a_if.rom_data_x <= rom_a[a_if.rom_addr[1:0]][0];
    a_if.rom_data_y <= rom_a[a_if.rom_addr[1:0]][1];
    a_if.rom_data_z <= rom_a[a_if.rom_addr[1:0]][2];
    b_if.rom_data_x <= rom_b[b_if.rom_addr[1:0]][0];
    b_if.rom_data_y <= rom_b[b_if.rom_addr[1:0]][1];
    b_if.rom_data_z <= rom_b[b_if.rom_addr[1:0]][2];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int model_pos [3];
  bit done_seen = 1'b0;

  always @(negedge clk) if (a_if.done === 1'b1) done_seen = 1'b1;

  task automatic set_model_home();
    for (int a = 0; a < 3; a++) model_pos[a] = 10;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_if.start = 1'b0; a_if.stop = 1'b0; a_if.loop_en = 1'b0;
    b_if.start = 1'b0; b_if.stop = 1'b0; b_if.loop_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_if.pos_x, a_if.pos_y, a_if.pos_z} !== {8'd10, 8'd10, 8'd10}) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d,%0d) want (10,10,10)", a_if.pos_x, a_if.pos_y, a_if.pos_z);
    end
    n_cmp++;
    if (a_if.rom_addr !== 6'd0 || a_if.cur_index !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got addr=%0d idx=%0d want 0/0", a_if.rom_addr, a_if.cur_index);
    end
    n_cmp++;
    if (a_if.pos_valid !== 1'b0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got pv=%b busy=%b done=%b want 0/0/0", a_if.pos_valid, a_if.busy, a_if.done);
    end
    rst = 1'b1;
    set_model_home();
  endtask

  task automatic pulse_start_a(input string name);
    a_if.start = 1'b0;
    @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n_cmp++;
    if (a_if.busy !== 1'b1 || a_if.rom_addr !== 6'd0 || a_if.cur_index !== 6'd0) begin
      n_fail++;
      $display("FAIL %s: one cycle after start got busy=%b addr=%0d idx=%0d want 1/0/0",
               name, a_if.busy, a_if.rom_addr, a_if.cur_index);
    end
  endtask

  // Expects one pos_valid pulse per motion tick until the model reaches the
  // waypoint; returns early once pos_y equals stop_y (stop_y < 0 disables).
  task automatic follow_point(input int idx, input int stop_y, output bit got_pulse);
    int tgt [3];
    bit ok;
    got_pulse = 1'b0;
    for (int a = 0; a < 3; a++) tgt[a] = int'(rom_a[idx][a]);
    while (model_pos[0] != tgt[0] || model_pos[1] != tgt[1] || model_pos[2] != tgt[2]) begin
      for (int a = 0; a < 3; a++) begin
        if (tgt[a] - model_pos[a] > ST)      model_pos[a] += ST;
        else if (model_pos[a] - tgt[a] > ST) model_pos[a] -= ST;
        else                                 model_pos[a] = tgt[a];
      end
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (a_if.pos_valid === 1'b1) begin ok = 1'b1; break; end
      end
      got_pulse = 1'b1;
      n_cmp++;
      if (!ok || a_if.pos_x !== 8'(model_pos[0]) || a_if.pos_y !== 8'(model_pos[1]) ||
          a_if.pos_z !== 8'(model_pos[2]) || a_if.cur_index !== 6'(idx)) begin
        n_fail++;
        $display("FAIL move_pt%0d: got pulse=%b pos=(%0d,%0d,%0d) idx=%0d want pulse=1 pos=(%0d,%0d,%0d) idx=%0d",
                 idx, ok, a_if.pos_x, a_if.pos_y, a_if.pos_z, a_if.cur_index,
                 model_pos[0], model_pos[1], model_pos[2], idx);
        return;
      end
      if (stop_y >= 0 && model_pos[1] == stop_y) return;
    end
  endtask

  // Two-tick dwell after the final pulse, then next index, wrap, or DONE.
  task automatic check_advance(input int idx, input bit had_pulse, input bit loop);
    bit fin;
    bit ok;
    bit spurious;
    int nxt;
    fin = (idx == NP - 1) && !loop;
    nxt = (idx == NP - 1) ? 0 : idx + 1;
    if (had_pulse) begin
      ok = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (a_if.cur_index !== 6'(idx) || a_if.busy !== 1'b1 || a_if.pos_valid !== 1'b0) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL hold_pt%0d: dwell cut short, got idx=%0d busy=%b want idx=%0d busy=1 for 2 ticks",
                 idx, a_if.cur_index, a_if.busy, idx);
      end
    end
    ok = 1'b0;
    spurious = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_if.pos_valid === 1'b1) spurious = 1'b1;
      if (fin ? (a_if.done === 1'b1 && a_if.busy === 1'b0)
              : (a_if.cur_index === 6'(nxt) && a_if.rom_addr === 6'(nxt) && a_if.busy === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || spurious) begin
      n_fail++;
      $display("FAIL advance_pt%0d: got idx=%0d addr=%0d done=%b busy=%b stray_pv=%b want %s",
               idx, a_if.cur_index, a_if.rom_addr, a_if.done, a_if.busy, spurious,
               fin ? "done=1 busy=0" : $sformatf("idx=addr=%0d busy=1", nxt));
    end
  endtask

  task automatic stop_pulse_a(input string name);
    @(negedge clk);
    a_if.stop = 1'b1;
    @(negedge clk);
    a_if.stop = 1'b0;
    n_cmp++;
    if (a_if.busy !== 1'b0 || a_if.pos_x !== 8'(model_pos[0]) ||
        a_if.pos_y !== 8'(model_pos[1]) || a_if.pos_z !== 8'(model_pos[2])) begin
      n_fail++;
      $display("FAIL %s: got busy=%b pos=(%0d,%0d,%0d) want busy=0 pos=(%0d,%0d,%0d)", name,
               a_if.busy, a_if.pos_x, a_if.pos_y, a_if.pos_z, model_pos[0], model_pos[1], model_pos[2]);
    end
  endtask

  task automatic test_one_shot();
    bit gp;
    bit ok;
    a_if.loop_en = 1'b0;
    pulse_start_a("start_latency");
    for (int p = 0; p < NP; p++) begin
      follow_point(p, -1, gp);
      check_advance(p, gp, 1'b0);
    end
    ok = 1'b1;
    repeat (20 * TD) begin
      @(negedge clk);
      if (a_if.pos_valid !== 1'b0 || a_if.done !== 1'b1 || a_if.busy !== 1'b0 ||
          {a_if.pos_x, a_if.pos_y, a_if.pos_z} !== 24'd0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_hold: got pos=(%0d,%0d,%0d) done=%b busy=%b pv=%b want (0,0,0) 1/0/0",
               a_if.pos_x, a_if.pos_y, a_if.pos_z, a_if.done, a_if.busy, a_if.pos_valid);
    end
  endtask

  task automatic test_loop();
    bit gp;
    a_if.loop_en = 1'b1;
    pulse_start_a("loop_start");
    done_seen = 1'b0;
    for (int p = 0; p < NP; p++) begin
      follow_point(p, -1, gp);
      check_advance(p, gp, 1'b1);
    end
    follow_point(0, -1, gp);
    n_cmp++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL loop_no_done: got done=1 during looped playback want 0");
    end
    stop_pulse_a("loop_stop");
    a_if.loop_en = 1'b0;
  endtask

  task automatic test_stop_and_start_priority();
    bit gp;
    bit ok;
    pulse_start_a("restart_from_idle");
    follow_point(0, -1, gp);
    check_advance(0, gp, 1'b0);
    follow_point(1, 74, gp);
    a_if.stop = 1'b1;
    @(negedge clk);
    a_if.stop = 1'b0;
    n_cmp++;
    if (a_if.busy !== 1'b0 || a_if.pos_y !== 8'd74 || a_if.pos_x !== 8'd30 || a_if.pos_z !== 8'd5) begin
      n_fail++;
      $display("FAIL stop_move: got busy=%b pos=(%0d,%0d,%0d) want busy=0 pos=(30,74,5)",
               a_if.busy, a_if.pos_x, a_if.pos_y, a_if.pos_z);
    end
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (a_if.pos_valid !== 1'b0 || a_if.pos_y !== 8'd74 || a_if.busy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stop_freeze: got pos_y=%0d pv=%b busy=%b want 74/0/0", a_if.pos_y, a_if.pos_valid, a_if.busy);
    end
    a_if.start = 1'b1;
    a_if.stop  = 1'b1;
    ok = 1'b1;
    repeat (3) begin @(negedge clk); if (a_if.busy !== 1'b0) ok = 1'b0; end
    a_if.stop = 1'b0;
    repeat (3) begin @(negedge clk); if (a_if.busy !== 1'b0) ok = 1'b0; end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL start_stop_priority: got busy=%b want 0", a_if.busy);
    end
    pulse_start_a("refetch_addr0");
    follow_point(0, -1, gp);
  endtask

  task automatic test_reset_mid_hold();
    bit gp;
    bit ok;
    a_if.start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_if.busy !== 1'b1 || a_if.cur_index !== 6'd0 || a_if.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_busy: got busy=%b idx=%0d pv=%b want 1/0/0", a_if.busy, a_if.cur_index, a_if.pos_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_if.pos_x, a_if.pos_y, a_if.pos_z} !== {8'd10, 8'd10, 8'd10} || a_if.rom_addr !== 6'd0 ||
        a_if.cur_index !== 6'd0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0 || a_if.pos_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pos=(%0d,%0d,%0d) addr=%0d busy=%b want (10,10,10) addr=0 busy=0",
               a_if.pos_x, a_if.pos_y, a_if.pos_z, a_if.rom_addr, a_if.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    set_model_home();
    ok = 1'b1;
    repeat (10) begin @(negedge clk); if (a_if.busy !== 1'b0) ok = 1'b0; end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL start_held_reset: got busy=%b want 0 while start stays high", a_if.busy);
    end
    pulse_start_a("start_after_reset");
    follow_point(0, -1, gp);
    check_advance(0, gp, 1'b0);
    stop_pulse_a("stop_after_reset_run");
  endtask

  task automatic test_hold_zero();
    bit ok;
    bit bad;
    @(negedge clk);
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    n_cmp++;
    if (b_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_start: got busy=%b want 1", b_if.busy);
    end
    ok = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (b_if.pos_valid === 1'b1) bad = 1'b1;
      if (b_if.cur_index === 6'd1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || bad) begin
      n_fail++;
      $display("FAIL hz_no_dwell: got idx=%0d stray_pv=%b want idx=1 without pulse", b_if.cur_index, bad);
    end
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b_if.pos_valid === 1'b1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || b_if.pos_x !== 8'd18 || b_if.pos_y !== 8'd10 || b_if.pos_z !== 8'd10 || b_if.cur_index !== 6'd1) begin
      n_fail++;
      $display("FAIL hz_next_move: got pulse=%b pos=(%0d,%0d,%0d) idx=%0d want pulse=1 (18,10,10) idx=1",
               ok, b_if.pos_x, b_if.pos_y, b_if.pos_z, b_if.cur_index);
    end
  endtask

  task automatic test_random();
    bit gp;
    for (int it = 0; it < 4; it++) begin
      stop_pulse_a("rand_idle");
      for (int p = 0; p < NP; p++)
        for (int a = 0; a < 3; a++) rom_a[p][a] = 8'($urandom_range(0, 255));
      a_if.loop_en = 1'b0;
      pulse_start_a("rand_start");
      for (int p = 0; p < NP; p++) begin
        follow_point(p, -1, gp);
        check_advance(p, gp, 1'b0);
      end
    end
  endtask

  initial begin
    rom_a[0] = '{8'd30, 8'd10,  8'd10};
    rom_a[1] = '{8'd30, 8'd200, 8'd5};
    rom_a[2] = '{8'd0,  8'd0,   8'd0};
    rom_a[3] = '{8'd0,  8'd0,   8'd0};
    rom_b[0] = '{8'd10, 8'd10,  8'd10};
    rom_b[1] = '{8'd20, 8'd10,  8'd10};
    rom_b[2] = '{8'd0,  8'd0,   8'd0};
    rom_b[3] = '{8'd0,  8'd0,   8'd0};
    test_reset();
    test_one_shot();
    test_loop();
    test_stop_and_start_priority();
    test_reset_mid_hold();
    test_hold_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
